// File: rtl/spi_lcd_pkg.sv
// Shared constants and types for the LCD SPI responder: opcodes, decoder states, widths.
`timescale 1ns/1ps
package spi_lcd_pkg;

    localparam int BYTE_W  = 8;
    localparam int COORD_W = 8;
    localparam int PIX_W   = 16;

    localparam logic [BYTE_W-1:0] CMD_CASET = 8'h2A;
    localparam logic [BYTE_W-1:0] CMD_RASET = 8'h2B;
    localparam logic [BYTE_W-1:0] CMD_RAMWR = 8'h2C;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CASET,
        ST_RASET,
        ST_RAMWR_HI,
        ST_RAMWR_LO
    } dec_state_e;

endpackage

// File: rtl/spi_byte_rx.sv
// Oversampling SPI byte receiver: synchronizers, SCK edge detect, MSB-first shifter, CSX abort.
// SPI_LCD_RX_STATS_EN adds the abort_o pulse used by the statistics counters.
`timescale 1ns/1ps
module spi_byte_rx
    import spi_lcd_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              csx_i,
    input  logic              dc_i,
    input  logic              sda_i,
    input  logic              sck_i,
    input  logic              rstx_i,
    output logic              rstx_sync_o,
    output logic              byte_valid_o,
    output logic [BYTE_W-1:0] byte_data_o,
    output logic              byte_dc_o
`ifdef SPI_LCD_RX_STATS_EN
    ,
    output logic              abort_o
`endif
);

    logic [SYNC_STAGES-1:0] csx_sync_q, dc_sync_q, sda_sync_q, sck_sync_q, rstx_sync_q;
    logic                   sck_prev_q, csx_prev_q;
    logic [2:0]             bit_cnt_q;
    logic [BYTE_W-2:0]      shift_q;
    logic                   byte_valid_q, byte_dc_q;
    logic [BYTE_W-1:0]      byte_data_q;

    logic csx_s, dc_s, sda_s, sck_s, rstx_s, sck_rise, local_rst;

    assign csx_s     = csx_sync_q[SYNC_STAGES-1];
    assign dc_s      = dc_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign sck_s     = sck_sync_q[SYNC_STAGES-1];
    assign rstx_s    = rstx_sync_q[SYNC_STAGES-1];
    assign sck_rise  = sck_s && !sck_prev_q;
    assign local_rst = !rst_n || !rstx_s;

    // Synchronizers only honour rst_n so the synced RSTX can release itself.
    // SCK history resets high so no phantom rising edge appears after reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csx_sync_q  <= '1;
            dc_sync_q   <= '0;
            sda_sync_q  <= '0;
            sck_sync_q  <= '1;
            rstx_sync_q <= '1;
            sck_prev_q  <= 1'b1;
            csx_prev_q  <= 1'b1;
        end else begin
            csx_sync_q  <= {csx_sync_q[SYNC_STAGES-2:0], csx_i};
            dc_sync_q   <= {dc_sync_q[SYNC_STAGES-2:0], dc_i};
            sda_sync_q  <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck_i};
            rstx_sync_q <= {rstx_sync_q[SYNC_STAGES-2:0], rstx_i};
            sck_prev_q  <= sck_s;
            csx_prev_q  <= csx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (local_rst) begin
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= '0;
            byte_dc_q    <= 1'b0;
        end else begin
            byte_valid_q <= 1'b0;
            if (csx_s) begin
                bit_cnt_q <= '0;
            end else if (sck_rise) begin
                shift_q   <= {shift_q[BYTE_W-3:0], sda_s};
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    byte_valid_q <= 1'b1;
                    byte_data_q  <= {shift_q, sda_s};
                    byte_dc_q    <= dc_s;
                end
            end
        end
    end

`ifdef SPI_LCD_RX_STATS_EN
    logic abort_q;
    always_ff @(posedge clk) begin
        if (local_rst) begin
            abort_q <= 1'b0;
        end else begin
            abort_q <= csx_s && !csx_prev_q && (bit_cnt_q != 3'd0);
        end
    end
    assign abort_o = abort_q;
`endif

    assign rstx_sync_o  = rstx_s;
    assign byte_valid_o = byte_valid_q;
    assign byte_data_o  = byte_data_q;
    assign byte_dc_o    = byte_dc_q;

endmodule

// File: rtl/spi_lcd_rx_decoder.sv
// LCD SPI responder: decodes CASET/RASET/RAMWR into clipped per-pixel writes.
// SPI_LCD_RX_STATS_EN adds saturating pixel/frame/abort statistics outputs.
`timescale 1ns/1ps
module spi_lcd_rx_decoder
    import spi_lcd_pkg::*;
#(
    parameter int H_RES       = 160,
    parameter int V_RES       = 80,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               LCD_CSX,
    input  logic               LCD_DC,
    input  logic               LCD_SDA,
    input  logic               LCD_SCK,
    input  logic               LCD_RSTX,
    output logic               cmd_valid,
    output logic [BYTE_W-1:0]  cmd_byte,
    output logic               pix_valid,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic [PIX_W-1:0]   pix_data,
    output logic               frame_done
`ifdef SPI_LCD_RX_STATS_EN
    ,
    output logic [31:0]        stat_pix_cnt,
    output logic [15:0]        stat_frame_cnt,
    output logic [15:0]        stat_abort_cnt
`endif
);

    logic              rstx_sync, byte_valid, byte_dc;
    logic [BYTE_W-1:0] byte_data;
`ifdef SPI_LCD_RX_STATS_EN
    logic              abort_pulse;
`endif

    spi_byte_rx #(.SYNC_STAGES(SYNC_STAGES)) u_byte_rx (
        .clk          (clk),
        .rst_n        (rst_n),
        .csx_i        (LCD_CSX),
        .dc_i         (LCD_DC),
        .sda_i        (LCD_SDA),
        .sck_i        (LCD_SCK),
        .rstx_i       (LCD_RSTX),
        .rstx_sync_o  (rstx_sync),
        .byte_valid_o (byte_valid),
        .byte_data_o  (byte_data),
        .byte_dc_o    (byte_dc)
`ifdef SPI_LCD_RX_STATS_EN
        ,
        .abort_o      (abort_pulse)
`endif
    );

    dec_state_e         state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [COORD_W-1:0] xs_q, xs_d, xe_q, xe_d, ys_q, ys_d, ye_q, ye_d;
    logic [COORD_W-1:0] cur_x_q, cur_x_d, cur_y_q, cur_y_d;
    logic [BYTE_W-1:0]  hi_q, hi_d, cmd_byte_q, cmd_byte_d;
    logic               cmd_valid_q, cmd_valid_d, pix_valid_q, pix_valid_d;
    logic               frame_done_q, frame_done_d;
    logic [COORD_W-1:0] pix_x_q, pix_x_d, pix_y_q, pix_y_d;
    logic [PIX_W-1:0]   pix_data_q, pix_data_d;
    logic               in_range;

    assign in_range = ({1'b0, cur_x_q} < 9'(H_RES)) && ({1'b0, cur_y_q} < 9'(V_RES));

    always_ff @(posedge clk) begin
        if (!rst_n || !rstx_sync) begin
            state_q      <= ST_IDLE;
            idx_q        <= '0;
            xs_q         <= '0;
            xe_q         <= COORD_W'(H_RES - 1);
            ys_q         <= '0;
            ye_q         <= COORD_W'(V_RES - 1);
            cur_x_q      <= '0;
            cur_y_q      <= '0;
            hi_q         <= '0;
            cmd_valid_q  <= 1'b0;
            cmd_byte_q   <= '0;
            pix_valid_q  <= 1'b0;
            pix_x_q      <= '0;
            pix_y_q      <= '0;
            pix_data_q   <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            xs_q         <= xs_d;
            xe_q         <= xe_d;
            ys_q         <= ys_d;
            ye_q         <= ye_d;
            cur_x_q      <= cur_x_d;
            cur_y_q      <= cur_y_d;
            hi_q         <= hi_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_byte_q   <= cmd_byte_d;
            pix_valid_q  <= pix_valid_d;
            pix_x_q      <= pix_x_d;
            pix_y_q      <= pix_y_d;
            pix_data_q   <= pix_data_d;
            frame_done_q <= frame_done_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        xs_d         = xs_q;
        xe_d         = xe_q;
        ys_d         = ys_q;
        ye_d         = ye_q;
        cur_x_d      = cur_x_q;
        cur_y_d      = cur_y_q;
        hi_d         = hi_q;
        cmd_valid_d  = 1'b0;
        cmd_byte_d   = cmd_byte_q;
        pix_valid_d  = 1'b0;
        pix_x_d      = pix_x_q;
        pix_y_d      = pix_y_q;
        pix_data_d   = pix_data_q;
        frame_done_d = 1'b0;
        if (byte_valid) begin
            if (!byte_dc) begin
                cmd_valid_d = 1'b1;
                cmd_byte_d  = byte_data;
                idx_d       = '0;
                case (byte_data)
                    CMD_CASET: state_d = ST_CASET;
                    CMD_RASET: state_d = ST_RASET;
                    CMD_RAMWR: begin
                        state_d = ST_RAMWR_HI;
                        cur_x_d = xs_q;
                        cur_y_d = ys_q;
                    end
                    default:   state_d = ST_IDLE;
                endcase
            end else begin
                // Window parameters are 16-bit on the wire; only the low bytes are kept.
                case (state_q)
                    ST_CASET, ST_RASET: begin
                        if (idx_q == 2'd1) begin
                            if (state_q == ST_CASET) xs_d = byte_data;
                            else                     ys_d = byte_data;
                        end
                        if (idx_q == 2'd3) begin
                            if (state_q == ST_CASET) xe_d = byte_data;
                            else                     ye_d = byte_data;
                            state_d = ST_IDLE;
                        end
                        idx_d = idx_q + 2'd1;
                    end
                    ST_RAMWR_HI: begin
                        hi_d    = byte_data;
                        state_d = ST_RAMWR_LO;
                    end
                    ST_RAMWR_LO: begin
                        if (in_range) begin
                            pix_valid_d = 1'b1;
                            pix_x_d     = cur_x_q;
                            pix_y_d     = cur_y_q;
                            pix_data_d  = {hi_q, byte_data};
                        end
                        frame_done_d = (cur_x_q == xe_q) && (cur_y_q == ye_q);
                        if (cur_x_q == xe_q) begin
                            cur_x_d = xs_q;
                            cur_y_d = (cur_y_q == ye_q) ? ys_q : cur_y_q + 8'd1;
                        end else begin
                            cur_x_d = cur_x_q + 8'd1;
                        end
                        state_d = ST_RAMWR_HI;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef SPI_LCD_RX_STATS_EN
    logic [31:0] stat_pix_q;
    logic [15:0] stat_frame_q, stat_abort_q;
    always_ff @(posedge clk) begin
        if (!rst_n || !rstx_sync) begin
            stat_pix_q   <= '0;
            stat_frame_q <= '0;
            stat_abort_q <= '0;
        end else begin
            if (pix_valid_q && stat_pix_q != '1)    stat_pix_q   <= stat_pix_q + 32'd1;
            if (frame_done_q && stat_frame_q != '1) stat_frame_q <= stat_frame_q + 16'd1;
            if (abort_pulse && stat_abort_q != '1)  stat_abort_q <= stat_abort_q + 16'd1;
        end
    end
    assign stat_pix_cnt   = stat_pix_q;
    assign stat_frame_cnt = stat_frame_q;
    assign stat_abort_cnt = stat_abort_q;
`endif

    assign cmd_valid  = cmd_valid_q;
    assign cmd_byte   = cmd_byte_q;
    assign pix_valid  = pix_valid_q;
    assign pix_x      = pix_x_q;
    assign pix_y      = pix_y_q;
    assign pix_data   = pix_data_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_spi_lcd_rx_decoder.sv
// Self-checking bench: bit-bangs the 4-wire LCD link and compares captured pixel/command/frame
// events against a window-and-cursor model of the panel.
`timescale 1ns/1ps
module tb_spi_lcd_rx_decoder;

    logic        clk = 1'b0, rst_n = 1'b0;
    logic        csx = 1'b1, dc = 1'b0, sda = 1'b0, sck = 1'b0, rstx = 1'b1;
    logic        cmd_valid, pix_valid, frame_done;
    logic [7:0]  cmd_byte, pix_x, pix_y;
    logic [15:0] pix_data;
`ifdef SPI_LCD_RX_STATS_EN
    logic [31:0] stat_pix_cnt;
    logic [15:0] stat_frame_cnt, stat_abort_cnt;
`endif

    spi_lcd_rx_decoder dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .LCD_CSX    (csx),
        .LCD_DC     (dc),
        .LCD_SDA    (sda),
        .LCD_SCK    (sck),
        .LCD_RSTX   (rstx),
        .cmd_valid  (cmd_valid),
        .cmd_byte   (cmd_byte),
        .pix_valid  (pix_valid),
        .pix_x      (pix_x),
        .pix_y      (pix_y),
        .pix_data   (pix_data),
        .frame_done (frame_done)
`ifdef SPI_LCD_RX_STATS_EN
        ,
        .stat_pix_cnt   (stat_pix_cnt),
        .stat_frame_cnt (stat_frame_cnt),
        .stat_abort_cnt (stat_abort_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int x;
        int y;
        int d;
    } pix_t;

    pix_t gotPix[$], expPix[$];
    int   gotFd[$], expFd[$], gotCmd[$], expCmd[$];
    int   compared = 0, mismatched = 0;
    int   mxs, mxe, mys, mye, mcx, mcy;

    // Frame-done entries record how many visible pixels had been written when it fired.
    always @(negedge clk) begin
        if (pix_valid) gotPix.push_back('{int'(pix_x), int'(pix_y), int'(pix_data)});
        if (frame_done) gotFd.push_back(gotPix.size());
        if (cmd_valid) gotCmd.push_back(int'(cmd_byte));
    end

    task automatic checkEq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        checkEq({tag, " pixCount"}, gotPix.size(), expPix.size());
        for (int i = 0; i < gotPix.size() && i < expPix.size(); i++) begin
            checkEq($sformatf("%s pix%0d.x", tag, i), gotPix[i].x, expPix[i].x);
            checkEq($sformatf("%s pix%0d.y", tag, i), gotPix[i].y, expPix[i].y);
            checkEq($sformatf("%s pix%0d.data", tag, i), gotPix[i].d, expPix[i].d);
        end
        checkEq({tag, " frameDoneCount"}, gotFd.size(), expFd.size());
        for (int i = 0; i < gotFd.size() && i < expFd.size(); i++)
            checkEq($sformatf("%s frameDone%0d", tag, i), gotFd[i], expFd[i]);
        checkEq({tag, " cmdCount"}, gotCmd.size(), expCmd.size());
        for (int i = 0; i < gotCmd.size() && i < expCmd.size(); i++)
            checkEq($sformatf("%s cmd%0d", tag, i), gotCmd[i], expCmd[i]);
        gotPix.delete(); expPix.delete(); gotFd.delete(); expFd.delete();
        gotCmd.delete(); expCmd.delete();
    endtask

    task automatic modelReset();
        mxs = 0; mxe = 159; mys = 0; mye = 79; mcx = 0; mcy = 0;
    endtask

    task automatic modelPixel(input int d);
        if (mcx < 160 && mcy < 80) expPix.push_back('{mcx, mcy, d});
        if (mcx == mxe && mcy == mye) expFd.push_back(expPix.size());
        if (mcx == mxe) begin
            mcx = mxs;
            mcy = (mcy == mye) ? mys : (mcy + 1) % 256;
        end else begin
            mcx = (mcx + 1) % 256;
        end
    endtask

    // One byte at SCK = clk/4: two clocks low with data set up, two clocks high.
    task automatic applyStimulus(input logic dcBit, input logic [7:0] b);
        dc = dcBit;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk) sck = 1'b0; sda = b[i];
            @(negedge clk);
            @(negedge clk) sck = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic beginTxn();
        @(negedge clk) csx = 1'b0;
    endtask

    task automatic endTxn();
        repeat (3) @(negedge clk);
        csx = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic sendCmd(input logic [7:0] b);
        applyStimulus(1'b0, b);
        expCmd.push_back(int'(b));
        if (b == 8'h2C) begin
            mcx = mxs; mcy = mys;
        end
    endtask

    task automatic sendWindow(input logic [7:0] op, input int s, input int e);
        beginTxn();
        sendCmd(op);
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'(s));
        applyStimulus(1'b1, 8'h00);
        applyStimulus(1'b1, 8'(e));
        endTxn();
        if (op == 8'h2A) begin mxs = s; mxe = e; end
        else begin mys = s; mye = e; end
    endtask

    task automatic sendRamwr(input int n, input logic useFixed, input logic [15:0] fixedData);
        logic [15:0] d;
        beginTxn();
        sendCmd(8'h2C);
        for (int i = 0; i < n; i++) begin
            d = useFixed ? fixedData : 16'($urandom);
            applyStimulus(1'b1, d[15:8]);
            applyStimulus(1'b1, d[7:0]);
            modelPixel(int'(d));
        end
        endTxn();
    endtask

    task automatic drainAndCheck(input string tag);
        repeat (12) @(negedge clk);
        checkOutput(tag);
    endtask

    initial begin
        int xs, xe, ys, ye, n;
        modelReset();
        repeat (5) @(negedge clk);
        checkEq("reset cmd_valid", cmd_valid, 0);
        checkEq("reset pix_valid", pix_valid, 0);
        checkEq("reset frame_done", frame_done, 0);
        checkEq("reset pix_data", pix_data, 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        sendRamwr(1, 1'b1, 16'hF800);
        drainAndCheck("firstPixel");

        sendWindow(8'h2A, 10, 12);
        sendWindow(8'h2B, 5, 6);
        sendRamwr(7, 1'b0, 16'h0);
        drainAndCheck("smallWindow");

        sendWindow(8'h2A, 158, 161);
        sendRamwr(5, 1'b0, 16'h0);
        drainAndCheck("rightClip");

        sendWindow(8'h2A, 250, 3);
        sendWindow(8'h2B, 0, 0);
        sendRamwr(12, 1'b0, 16'h0);
        drainAndCheck("reversedWindow");

        // Five bits then CSX high: the partial byte must vanish without disturbing the next one.
        beginTxn();
        dc = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk) sck = 1'b0; sda = 1'b1;
            @(negedge clk);
            @(negedge clk) sck = 1'b1;
            @(negedge clk);
        end
        csx = 1'b1;
        repeat (4) @(negedge clk);
        csx = 1'b0;
        sendCmd(8'h2C);
        endTxn();
        drainAndCheck("csxAbort");

        beginTxn();
        sendCmd(8'h2C);
        applyStimulus(1'b1, 8'hAB);
        @(negedge clk) rstx = 1'b0;
        repeat (6) @(negedge clk);
        checkEq("rstx cmd_byte", cmd_byte, 0);
        checkEq("rstx pix_x", pix_x, 0);
        checkEq("rstx pix_y", pix_y, 0);
        checkEq("rstx pix_data", pix_data, 0);
        rstx = 1'b1;
        repeat (4) @(negedge clk);
        modelReset();
        applyStimulus(1'b1, 8'hCD);
        applyStimulus(1'b1, 8'hEF);
        endTxn();
        drainAndCheck("rstxDropped");
        sendRamwr(2, 1'b0, 16'h0);
        drainAndCheck("rstxWindow");

        for (int r = 0; r < 4; r++) begin
            xs = $urandom_range(0, 165);
            xe = xs + $urandom_range(0, 6);
            ys = $urandom_range(0, 82);
            ye = ys + $urandom_range(0, 3);
            n  = $urandom_range(1, (xe - xs + 1) * (ye - ys + 1) + 3);
            sendWindow(8'h2A, xs, xe);
            sendWindow(8'h2B, ys, ye);
            sendRamwr(n, 1'b0, 16'h0);
            drainAndCheck($sformatf("random%0d", r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
